// File: rtl/omp_pkg.sv
// Shared types and defaults for the OMP sequencer: state encoding, termination codes, size defaults.
package omp_pkg;

  localparam int unsigned N_MAX_DEF = 64;
  localparam int unsigned M_MAX_DEF = 8;
  localparam int unsigned K_MAX_DEF = 16;
  localparam int unsigned DW_DEF    = 96;
  localparam int unsigned EW_DEF    = 48;

  typedef enum logic [3:0] {
    IDLE,
    CHK,
    INIT,
    A_GO,
    A_WAIT,
    LATCH,
    B_GO,
    B_WAIT,
    NEXT,
    FIN
  } omp_state_e;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_CFG  = 2'd1;
  localparam logic [1:0] ERR_ATOM = 2'd2;
  localparam logic [1:0] ERR_STOP = 2'd3;

endpackage

// File: rtl/omp_init_copy.sv
// Copies y words 0..m_cfg-1 into residual rows; the write trails the read by the y memory latency.
module omp_init_copy #(
  parameter  int unsigned M_MAX = 8,
  localparam int unsigned MW    = $clog2(M_MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [MW:0]   m_cfg,
  output logic [MW-1:0] y_addr,
  output logic [MW-1:0] r_addr,
  output logic          r_we,
  output logic          last_c
);

  logic [MW:0] cnt;

  // cnt runs 0..m_cfg while enabled; the final count is the drain cycle for the last write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      r_addr <= '0;
      r_we   <= 1'b0;
    end else begin
      cnt    <= en ? cnt + (MW+1)'(1) : '0;
      r_we   <= en && (cnt < m_cfg);
      r_addr <= en ? cnt[MW-1:0] : '0;
    end
  end

  assign y_addr = cnt[MW-1:0];
  assign last_c = en && (cnt == m_cfg);

endmodule

// File: rtl/omp_seq_gen.sv
// OMP iteration sequencer: validates config, seeds the residual, then alternates atom-select and
// orthogonalisation engines. Optional early stop on residual energy under RESIDUAL_STOP_EN.
module omp_seq_gen
  import omp_pkg::*;
#(
  parameter  int unsigned N_MAX = N_MAX_DEF,
  parameter  int unsigned M_MAX = M_MAX_DEF,
  parameter  int unsigned K_MAX = K_MAX_DEF,
  parameter  int unsigned DW    = DW_DEF,
  parameter  int unsigned EW    = EW_DEF,
  localparam int unsigned LW    = $clog2(N_MAX),
  localparam int unsigned MW    = $clog2(M_MAX),
  localparam int unsigned KW    = $clog2(K_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LW:0]      n_cfg,
  input  logic [MW:0]      m_cfg,
  input  logic [KW-1:0]    k_cfg,
  input  logic [EW-1:0]    thr,
  output logic [MW-1:0]    y_addr,
  input  logic [DW-1:0]    y_rdata,
  output logic [MW-1:0]    r_addr,
  output logic [DW-1:0]    r_wdata,
  output logic             r_we,
  output logic             a_start,
  input  logic             a_done,
  input  logic [LW-1:0]    a_lambda,
  output logic             b_start,
  input  logic             b_done,
  input  logic [EW-1:0]    b_energy,
  output logic [N_MAX-1:0] sel_mask,
  output logic [LW-1:0]    lambda_out,
  output logic             lambda_we,
  output logic [KW-1:0]    iter,
  output logic             busy,
  output logic             done,
  output logic [KW-1:0]    final_k,
  output logic [1:0]       err
);

  omp_state_e       state, state_d;
  logic             busy_d, done_d, a_start_d, b_start_d, lambda_we_d;
  logic [N_MAX-1:0] sel_mask_d;
  logic [LW-1:0]    lambda_out_d;
  logic [KW-1:0]    iter_d, final_k_d;
  logic [1:0]       err_d;
  logic             copy_en, copy_last_c, cfg_bad_c, atom_bad_c;

`ifndef RESIDUAL_STOP_EN
  logic unused_stop;
  assign unused_stop = ^{thr, b_energy};
`endif

  assign copy_en = (state == INIT) && !abort;

  omp_init_copy #(.M_MAX(M_MAX)) u_copy (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (copy_en),
    .m_cfg  (m_cfg),
    .y_addr (y_addr),
    .r_addr (r_addr),
    .r_we   (r_we),
    .last_c (copy_last_c)
  );

  // y memory has one cycle of latency, so its data lines up with the delayed write address
  assign r_wdata = y_rdata;

  assign cfg_bad_c = (n_cfg == '0) || (32'(n_cfg) > N_MAX) ||
                     (m_cfg == '0) || (32'(m_cfg) > M_MAX) ||
                     (k_cfg == '0) || (32'(k_cfg) > K_MAX) ||
                     (32'(k_cfg) > 32'(m_cfg));
  assign atom_bad_c = (32'(a_lambda) >= 32'(n_cfg)) || sel_mask[a_lambda];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      a_start    <= 1'b0;
      b_start    <= 1'b0;
      lambda_we  <= 1'b0;
      lambda_out <= '0;
      sel_mask   <= '0;
      iter       <= '0;
      final_k    <= '0;
      err        <= ERR_OK;
    end else begin
      state      <= state_d;
      busy       <= busy_d;
      done       <= done_d;
      a_start    <= a_start_d;
      b_start    <= b_start_d;
      lambda_we  <= lambda_we_d;
      lambda_out <= lambda_out_d;
      sel_mask   <= sel_mask_d;
      iter       <= iter_d;
      final_k    <= final_k_d;
      err        <= err_d;
    end
  end

  // Next state plus next output values; strobes are raised on entry to the state that owns them
  always_comb begin
    state_d      = state;
    busy_d       = busy;
    done_d       = 1'b0;
    a_start_d    = 1'b0;
    b_start_d    = 1'b0;
    lambda_we_d  = 1'b0;
    lambda_out_d = lambda_out;
    sel_mask_d   = sel_mask;
    iter_d       = iter;
    final_k_d    = final_k;
    err_d        = err;

    unique case (state)
      IDLE: if (start) begin
        state_d    = CHK;
        busy_d     = 1'b1;
        sel_mask_d = '0;
        iter_d     = '0;
        final_k_d  = '0;
        err_d      = ERR_OK;
      end
      CHK: if (cfg_bad_c) begin
        state_d = FIN;
        err_d   = ERR_CFG;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        state_d = INIT;
      end
      INIT: if (copy_last_c) begin
        state_d   = A_GO;
        a_start_d = 1'b1;
      end
      A_GO: state_d = A_WAIT;
      A_WAIT: if (a_done) begin
        if (atom_bad_c) begin
          state_d = FIN;
          err_d   = ERR_ATOM;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d              = LATCH;
          sel_mask_d[a_lambda] = 1'b1;
          lambda_out_d         = a_lambda;
          lambda_we_d          = 1'b1;
          final_k_d            = final_k + KW'(1);
        end
      end
      LATCH: begin
        state_d   = B_GO;
        b_start_d = 1'b1;
      end
      B_GO: state_d = B_WAIT;
      B_WAIT: if (b_done) begin
`ifdef RESIDUAL_STOP_EN
        if (b_energy < thr) begin
          state_d = FIN;
          err_d   = ERR_STOP;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = NEXT;
        end
`else
        state_d = NEXT;
`endif
      end
      NEXT: if (iter == KW'(k_cfg - KW'(1))) begin
        state_d = FIN;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        iter_d    = iter + KW'(1);
        state_d   = A_GO;
        a_start_d = 1'b1;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort discards any transition this cycle, including a coincident engine completion
    if (abort && (state != IDLE)) begin
      state_d      = IDLE;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      a_start_d    = 1'b0;
      b_start_d    = 1'b0;
      lambda_we_d  = 1'b0;
      lambda_out_d = lambda_out;
      sel_mask_d   = sel_mask;
      iter_d       = iter;
      final_k_d    = final_k;
      err_d        = err;
    end
  end

endmodule

// File: tb/tb_omp_seq_gen.sv
// Self-checking bench for omp_seq_gen: directed scenarios plus randomized runs against a reference model.
module tb_omp_seq_gen;

  localparam int LW = 6, MW = 3, KW = 5, DW = 96, EW = 48, NM = 64;

  logic          clk, rst_n, start, abort;
  logic [LW:0]   n_cfg;
  logic [MW:0]   m_cfg;
  logic [KW-1:0] k_cfg;
  logic [EW-1:0] thr, b_energy;
  logic [MW-1:0] y_addr, r_addr;
  logic [DW-1:0] y_rdata, r_wdata;
  logic          r_we, a_start, a_done, b_start, b_done, lambda_we, busy, done;
  logic [LW-1:0] a_lambda, lambda_out;
  logic [NM-1:0] sel_mask;
  logic [KW-1:0] iter, final_k;
  logic [1:0]    err;

  omp_seq_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .n_cfg(n_cfg), .m_cfg(m_cfg),
    .k_cfg(k_cfg), .thr(thr), .y_addr(y_addr), .y_rdata(y_rdata), .r_addr(r_addr),
    .r_wdata(r_wdata), .r_we(r_we), .a_start(a_start), .a_done(a_done), .a_lambda(a_lambda),
    .b_start(b_start), .b_done(b_done), .b_energy(b_energy), .sel_mask(sel_mask),
    .lambda_out(lambda_out), .lambda_we(lambda_we), .iter(iter), .busy(busy), .done(done),
    .final_k(final_k), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  logic [DW-1:0] y_mem [8];
  logic [MW-1:0] prev_yaddr = '0;
  logic [LW-1:0] lam_q[$], obs_lam[$], exp_lam[$];
  logic [EW-1:0] en_q[$];
  logic [MW-1:0] obs_raddr[$];
  logic [DW-1:0] obs_rdata[$];
  int obs_done, obs_astart, obs_first_a, obs_done_cyc, obs_busy1, obs_busy_done;
  int obs_timeout, obs_busy_ab, obs_strobe_ab;
  logic [NM-1:0] exp_mask;
  int exp_k, exp_err, exp_astart;

  // Reference: walk the proposed atom list applying the acceptance and stop rules directly
  task automatic model_run(input int n, input int m, input int k, input logic [EW-1:0] th);
    bit seen [64];
    int l;
    exp_lam.delete(); exp_mask = '0; exp_k = 0; exp_err = 0; exp_astart = 0;
    foreach (seen[i]) seen[i] = 0;
    if (n == 0 || n > 64 || m == 0 || m > 8 || k == 0 || k > 16 || k > m) begin
      exp_err = 1;
      return;
    end
    for (int i = 0; i < k; i++) begin
      exp_astart++;
      l = (i < lam_q.size()) ? int'(lam_q[i]) : 0;
      if (l >= n || seen[l]) begin exp_err = 2; break; end
      seen[l] = 1; exp_mask[l] = 1'b1; exp_k++; exp_lam.push_back(LW'(l));
`ifdef RESIDUAL_STOP_EN
      if (((i < en_q.size()) ? en_q[i] : {EW{1'b1}}) < th) begin exp_err = 3; break; end
`endif
    end
  endtask

  // Drive one run with behavioural A/B engines and a 1-cycle y memory; record what the DUT did
  task automatic run_job(input int n, input int m, input int k, input logic [EW-1:0] th,
                         input int abort_b, input bit poke_start);
    int cyc, a_wait, b_wait, nb, tail, abort_cd, abort_cyc;
    bit fin, aborted;
    obs_lam.delete(); obs_raddr.delete(); obs_rdata.delete();
    obs_done = 0; obs_astart = 0; obs_first_a = -1; obs_done_cyc = -1; obs_busy1 = -1;
    obs_busy_done = -1; obs_timeout = 0; obs_busy_ab = -1; obs_strobe_ab = 0;
    a_wait = 0; b_wait = 0; nb = 0; tail = 0; abort_cd = 0; abort_cyc = -10; fin = 0; aborted = 0;
    n_cfg = (LW+1)'(n); m_cfg = (MW+1)'(m); k_cfg = KW'(k); thr = th;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (1) begin
      y_rdata = y_mem[prev_yaddr]; prev_yaddr = y_addr;
      if (cyc == 1) obs_busy1 = int'(busy);
      if (aborted && cyc == abort_cyc + 1) obs_busy_ab = int'(busy);
      if (aborted && cyc > abort_cyc && (a_start || b_start || lambda_we || r_we || done))
        obs_strobe_ab++;
      if (a_start) begin
        obs_astart++;
        if (obs_first_a < 0) obs_first_a = cyc;
        a_wait = $urandom_range(2, 4);
      end
      if (b_start) begin
        nb++;
        if (nb == abort_b) begin abort_cd = 2; b_wait = 0; end
        else b_wait = $urandom_range(2, 4);
      end
      if (lambda_we) obs_lam.push_back(lambda_out);
      if (r_we) begin obs_raddr.push_back(r_addr); obs_rdata.push_back(r_wdata); end
      if (done) begin
        obs_done++;
        if (obs_done_cyc < 0) begin obs_done_cyc = cyc; obs_busy_done = int'(busy); end
        fin = 1;
      end
      a_done = 1'b0; b_done = 1'b0; abort = 1'b0;
      start = (poke_start && cyc == 4);
      if (abort_cd > 0) begin
        abort_cd--;
        if (abort_cd == 0) begin
          abort = 1'b1; b_done = 1'b1; b_energy = '0; aborted = 1; abort_cyc = cyc;
        end
      end
      if (a_wait > 0) begin
        a_wait--;
        if (a_wait == 0) begin
          a_done = 1'b1;
          a_lambda = (lam_q.size() > 0) ? lam_q.pop_front() : '0;
        end else if ($urandom_range(0, 2) == 0) begin
          b_done = 1'b1; b_energy = '0;
        end
      end
      if (b_wait > 0) begin
        b_wait--;
        if (b_wait == 0) begin
          b_done = 1'b1;
          b_energy = (en_q.size() > 0) ? en_q.pop_front() : {EW{1'b1}};
        end else if ($urandom_range(0, 2) == 0) begin
          a_done = 1'b1; a_lambda = '0;
        end
      end
      if (fin || aborted) tail++;
      if (tail > 8) break;
      if (cyc > 600) begin obs_timeout = 1; break; end
      @(posedge clk); #1;
      cyc++;
    end
    a_done = 1'b0; b_done = 1'b0; abort = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; a_done = 0; b_done = 0; a_lambda = '0; b_energy = '0;
    n_cfg = '0; m_cfg = '0; k_cfg = '0; thr = '0; y_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({busy, done, a_start, b_start, lambda_we, r_we} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000000", {busy, done, a_start, b_start, lambda_we, r_we}); end
    n_cmp++; if (sel_mask !== 64'd0) begin
      n_fail++; $display("FAIL reset_mask: got %h want 0", sel_mask); end
    n_cmp++; if ({y_addr, r_addr, err, final_k, iter, lambda_out} !== 24'd0) begin
      n_fail++; $display("FAIL reset_fields: got %h want 0", {y_addr, r_addr, err, final_k, iter, lambda_out}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    lam_q = '{6'd5, 6'd9, 6'd2, 6'd40}; en_q = '{48'd1000, 48'd1000, 48'd1000, 48'd1000};
    run_job(64, 8, 4, 48'd0, 0, 1'b1);
    n_cmp++; if (obs_lam.size() !== 4) begin
      n_fail++; $display("FAIL basic_we_count: got %0d want 4", obs_lam.size()); end
    for (int i = 0; i < obs_lam.size() && i < 4; i++) begin
      n_cmp++; if (obs_lam[i] !== (i == 0 ? 6'd5 : i == 1 ? 6'd9 : i == 2 ? 6'd2 : 6'd40)) begin
        n_fail++; $display("FAIL basic_lambda%0d: got %0d", i, obs_lam[i]); end
    end
    n_cmp++; if (obs_done !== 1 || obs_busy_done !== 0 || obs_busy1 !== 1) begin
      n_fail++; $display("FAIL basic_done: got done=%0d busy@done=%0d busy@1=%0d want 1 0 1", obs_done, obs_busy_done, obs_busy1); end
    n_cmp++; if (final_k !== 5'd4 || err !== 2'd0) begin
      n_fail++; $display("FAIL basic_result: got k=%0d err=%0d want 4 0", final_k, err); end
    n_cmp++; if (sel_mask !== ((64'd1 << 2) | (64'd1 << 5) | (64'd1 << 9) | (64'd1 << 40))) begin
      n_fail++; $display("FAIL basic_mask: got %h", sel_mask); end
  endtask

  task automatic test_init_copy();
    lam_q = '{6'd1, 6'd2, 6'd3}; en_q = '{48'd1000, 48'd1000, 48'd1000};
    run_job(10, 3, 3, 48'd0, 0, 1'b0);
    n_cmp++; if (obs_raddr.size() !== 3) begin
      n_fail++; $display("FAIL init_we_count: got %0d want 3", obs_raddr.size()); end
    for (int i = 0; i < obs_raddr.size() && i < 3; i++) begin
      n_cmp++; if (obs_raddr[i] !== MW'(i) || obs_rdata[i] !== y_mem[i]) begin
        n_fail++; $display("FAIL init_row%0d: got addr %0d data %h want %0d %h", i, obs_raddr[i], obs_rdata[i], i, y_mem[i]); end
    end
    n_cmp++; if (obs_first_a !== 6) begin
      n_fail++; $display("FAIL init_a_start_cycle: got %0d want 6", obs_first_a); end
  endtask

  task automatic test_dup_and_range();
    lam_q = '{6'd9, 6'd9, 6'd1, 6'd2}; en_q = '{48'd1000, 48'd1000, 48'd1000, 48'd1000};
    run_job(64, 8, 4, 48'd0, 0, 1'b0);
    n_cmp++; if (err !== 2'd2 || final_k !== 5'd1 || obs_done !== 1) begin
      n_fail++; $display("FAIL dup: got err=%0d k=%0d done=%0d want 2 1 1", err, final_k, obs_done); end
    lam_q = '{6'd12}; en_q = '{48'd1000};
    run_job(10, 4, 2, 48'd0, 0, 1'b0);
    n_cmp++; if (err !== 2'd2 || final_k !== 5'd0 || sel_mask !== 64'd0) begin
      n_fail++; $display("FAIL range: got err=%0d k=%0d mask=%h want 2 0 0", err, final_k, sel_mask); end
  endtask

  task automatic test_bad_cfg();
    int cfgs [7][3] = '{'{64, 8, 0}, '{0, 8, 2}, '{65, 8, 2}, '{64, 0, 1}, '{64, 9, 2},
                        '{64, 8, 17}, '{64, 3, 4}};
    for (int c = 0; c < 7; c++) begin
      lam_q = '{6'd1}; en_q.delete();
      run_job(cfgs[c][0], cfgs[c][1], cfgs[c][2], 48'd0, 0, 1'b0);
      n_cmp++; if (err !== 2'd1 || obs_astart !== 0 || obs_done !== 1 || obs_done_cyc !== 2) begin
        n_fail++; $display("FAIL badcfg%0d: got err=%0d a_start=%0d done=%0d at %0d want 1 0 1 2",
                           c, err, obs_astart, obs_done, obs_done_cyc); end
    end
  endtask

  task automatic test_abort();
    lam_q = '{6'd3, 6'd7, 6'd11, 6'd13}; en_q = '{48'd1000, 48'd1000, 48'd1000, 48'd1000};
    run_job(64, 8, 4, 48'd100, 2, 1'b0);
    n_cmp++; if (obs_busy_ab !== 0 || obs_done !== 0 || obs_strobe_ab !== 0) begin
      n_fail++; $display("FAIL abort: got busy=%0d done=%0d strobes=%0d want 0 0 0", obs_busy_ab, obs_done, obs_strobe_ab); end
    n_cmp++; if (final_k !== 5'd2 || sel_mask !== ((64'd1 << 3) | (64'd1 << 7))) begin
      n_fail++; $display("FAIL abort_frozen: got k=%0d mask=%h want 2", final_k, sel_mask); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || final_k !== 5'd2 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got busy=%0d k=%0d done=%0d want 0 2 0", busy, final_k, done); end
  endtask

  task automatic test_random();
    int n, m, k, r;
    logic [EW-1:0] th;
    logic [LW-1:0] l;
    for (int run = 0; run < 10; run++) begin
      n = $urandom_range(1, 64); m = $urandom_range(1, 8); k = $urandom_range(1, m);
      th = EW'($urandom_range(50, 400));
      lam_q.delete(); en_q.delete();
      for (int i = 0; i < k; i++) begin
        r = $urandom_range(0, 15);
        if (r == 0 && i > 0) l = lam_q[$urandom_range(0, i - 1)];
        else if (r == 1 && n < 64) l = LW'($urandom_range(n, 63));
        else l = LW'($urandom_range(0, n - 1));
        lam_q.push_back(l);
        en_q.push_back(EW'($urandom_range(0, 2000)));
      end
      model_run(n, m, k, th);
      run_job(n, m, k, th, 0, run[0]);
      n_cmp++; if (obs_lam.size() !== exp_lam.size() || obs_astart !== exp_astart) begin
        n_fail++; $display("FAIL rand%0d_counts: got we=%0d a=%0d want %0d %0d", run, obs_lam.size(), obs_astart, exp_lam.size(), exp_astart); end
      for (int i = 0; i < obs_lam.size() && i < exp_lam.size(); i++) begin
        n_cmp++; if (obs_lam[i] !== exp_lam[i]) begin
          n_fail++; $display("FAIL rand%0d_lambda%0d: got %0d want %0d", run, i, obs_lam[i], exp_lam[i]); end
      end
      n_cmp++; if (final_k !== KW'(exp_k) || err !== 2'(exp_err) || sel_mask !== exp_mask ||
                   obs_done !== 1 || obs_busy_done !== 0 || obs_timeout !== 0) begin
        n_fail++; $display("FAIL rand%0d_result: got k=%0d err=%0d done=%0d to=%0d want k=%0d err=%0d", run, final_k, err, obs_done, obs_timeout, exp_k, exp_err); end
    end
  endtask

`ifdef RESIDUAL_STOP_EN
  task automatic test_stop();
    lam_q = '{6'd3, 6'd7, 6'd11, 6'd13}; en_q = '{48'd500, 48'd50, 48'd500, 48'd500};
    run_job(64, 8, 4, 48'd100, 0, 1'b0);
    n_cmp++; if (err !== 2'd3 || final_k !== 5'd2 || obs_done !== 1) begin
      n_fail++; $display("FAIL stop: got err=%0d k=%0d done=%0d want 3 2 1", err, final_k, obs_done); end
  endtask
`endif

  task automatic test_reset_mid();
    int seen_done;
    lam_q = '{6'd4, 6'd5}; en_q = '{48'd1000, 48'd1000};
    n_cfg = 7'd64; m_cfg = 4'd8; k_cfg = 5'd2; thr = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || r_we !== 1'b0 || y_addr !== 3'd0 || sel_mask !== 64'd0) begin
      n_fail++; $display("FAIL reset_mid: got busy=%0d r_we=%0d y_addr=%0d", busy, r_we, y_addr); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_done = 0;
    repeat (10) begin @(posedge clk); #1; if (done || busy) seen_done++; end
    n_cmp++; if (seen_done !== 0) begin
      n_fail++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", seen_done); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) y_mem[i] = {$urandom(), $urandom(), $urandom()};
    test_reset();
    test_basic();
    test_init_copy();
    test_dup_and_range();
    test_bad_cfg();
    test_abort();
    test_random();
`ifdef RESIDUAL_STOP_EN
    test_stop();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
